// File: rtl/cpu_port_harness.sv
// Run controller for the yfcpu core.
// Holds the CPU in reset until started, then feeds the CPU input port from a
// preloaded stimulus buffer. Every change on the CPU output port is pushed
// into a capture FIFO. A run ends on a PC halt loop or on a cycle timeout;
// the capture FIFO can then be drained.
module cpu_port_harness #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 16,
    parameter int STIM_DEPTH = 16,
    parameter int CAP_DEPTH  = 16,
    parameter int TIMEOUT    = 650,
    parameter int HALT_CYC   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stim_wr_en,
    input  logic [DATA_W-1:0]          stim_wr_data,
    input  logic                       cap_rd_en,
    output logic [DATA_W-1:0]          cap_rd_data,
    output logic [$clog2(CAP_DEPTH):0] cap_count,
    output logic                       cpu_rst,
    output logic [DATA_W-1:0]          cpu_in,
    input  logic [DATA_W-1:0]          cpu_out,
    input  logic [PC_W-1:0]            cpu_pc,
    output logic                       running,
    output logic                       done,
    output logic                       halted,
    output logic                       timed_out,
    output logic                       cap_ovf,
    output logic [15:0]                cycle_count
);

    localparam int SAW = $clog2(STIM_DEPTH);
    localparam int CAW = $clog2(CAP_DEPTH);
    localparam int STW = $clog2(HALT_CYC) + 1;

    localparam logic [SAW:0]   STIM_FULL  = (SAW+1)'(STIM_DEPTH);
    localparam logic [CAW:0]   CAP_FULL   = (CAW+1)'(CAP_DEPTH);
    localparam logic [STW-1:0] HALT_LIM   = STW'(HALT_CYC - 1);
    localparam logic [31:0]    TIMEOUT_W  = 32'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Storage arrays (no reset; contents are qualified by the counters)
    logic [DATA_W-1:0] stim_mem [STIM_DEPTH];
    logic [DATA_W-1:0] cap_mem  [CAP_DEPTH];

    logic [1:0]        state_q, state_d;
    // Number of stimulus entries written; its low bits are the write pointer
    logic [SAW:0]      stim_cnt_q, stim_cnt_d;
    // Set when a run finishes: next stimulus write starts over at entry 0
    logic              stim_restart_q, stim_restart_d;
    logic [SAW-1:0]    stim_rd_ptr_q, stim_rd_ptr_d;
    logic [DATA_W-1:0] cpu_in_q, cpu_in_d;
    logic [CAW-1:0]    cap_wr_ptr_q, cap_wr_ptr_d;
    logic [CAW-1:0]    cap_rd_ptr_q, cap_rd_ptr_d;
    logic [CAW:0]      cap_count_q, cap_count_d;
    logic [DATA_W-1:0] cap_rd_data_q, cap_rd_data_d;
    logic [DATA_W-1:0] prev_out_q, prev_out_d;
    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic [STW-1:0]    stab_q, stab_d;
    logic [15:0]       cycle_count_q, cycle_count_d;
    logic              halted_q, halted_d;
    logic              timed_out_q, timed_out_d;
    logic              cap_ovf_q, cap_ovf_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              stim_we;
    logic [SAW-1:0]    stim_wr_idx;
    logic              cap_we;
    logic              out_changed;
    logic [SAW:0]      stim_rd_nxt;
    logic              halt_hit;
    logic              timeout_hit;

    assign out_changed = (cpu_out != prev_out_q);
    assign stim_rd_nxt = {1'b0, stim_rd_ptr_q} + 1'b1;

    // Next-state logic for the controller, stimulus feed and capture FIFO
    always_comb begin
        state_d        = state_q;
        stim_cnt_d     = stim_cnt_q;
        stim_restart_d = stim_restart_q;
        stim_rd_ptr_d  = stim_rd_ptr_q;
        cpu_in_d       = cpu_in_q;
        cap_wr_ptr_d   = cap_wr_ptr_q;
        cap_rd_ptr_d   = cap_rd_ptr_q;
        cap_count_d    = cap_count_q;
        cap_rd_data_d  = cap_rd_data_q;
        prev_out_d     = prev_out_q;
        prev_pc_d      = prev_pc_q;
        stab_d         = stab_q;
        cycle_count_d  = cycle_count_q;
        halted_d       = halted_q;
        timed_out_d    = timed_out_q;
        cap_ovf_d      = cap_ovf_q;
        cpu_rst_d      = cpu_rst_q;
        stim_we        = 1'b0;
        stim_wr_idx    = stim_cnt_q[SAW-1:0];
        cap_we         = 1'b0;
        halt_hit       = 1'b0;
        timeout_hit    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                cpu_rst_d = 1'b1;
                // Stimulus loading; the first write after a run restarts at entry 0
                if (stim_wr_en) begin
                    if (stim_restart_q) begin
                        stim_we        = 1'b1;
                        stim_wr_idx    = '0;
                        stim_cnt_d     = {{SAW{1'b0}}, 1'b1};
                        stim_restart_d = 1'b0;
                    end else if (stim_cnt_q < STIM_FULL) begin
                        stim_we    = 1'b1;
                        stim_cnt_d = stim_cnt_q + 1'b1;
                    end
                end
                // Capture readback is only meaningful once a run has finished
                if (state_q == S_DONE && cap_rd_en && cap_count_q != '0) begin
                    cap_rd_data_d = cap_mem[cap_rd_ptr_q];
                    cap_rd_ptr_d  = cap_rd_ptr_q + 1'b1;
                    cap_count_d   = cap_count_q - 1'b1;
                end
                if (start) begin
                    state_d       = S_RUN;
                    cpu_rst_d     = 1'b0;
                    cap_wr_ptr_d  = '0;
                    cap_rd_ptr_d  = '0;
                    cap_count_d   = '0;
                    cap_ovf_d     = 1'b0;
                    halted_d      = 1'b0;
                    timed_out_d   = 1'b0;
                    cycle_count_d = '0;
                    stab_d        = '0;
                    stim_rd_ptr_d = '0;
                    cpu_in_d      = (stim_cnt_q != '0) ? stim_mem[0] : '0;
                    prev_out_d    = cpu_out;
                    prev_pc_d     = cpu_pc;
                end
            end

            S_RUN: begin
                cpu_rst_d     = 1'b0;
                cycle_count_d = (cycle_count_q == 16'hFFFF) ? cycle_count_q
                                                            : cycle_count_q + 16'd1;
                prev_out_d    = cpu_out;
                prev_pc_d     = cpu_pc;
                if (cpu_pc == prev_pc_q) begin
                    stab_d = (stab_q == HALT_LIM) ? stab_q : stab_q + 1'b1;
                end else begin
                    stab_d = '0;
                end
                // Each output change is captured and advances the stimulus feed
                if (out_changed) begin
                    if (cap_count_q == CAP_FULL) begin
                        cap_ovf_d = 1'b1;
                    end else begin
                        cap_we       = 1'b1;
                        cap_wr_ptr_d = cap_wr_ptr_q + 1'b1;
                        cap_count_d  = cap_count_q + 1'b1;
                    end
                    if (stim_rd_nxt < stim_cnt_q) begin
                        stim_rd_ptr_d = stim_rd_nxt[SAW-1:0];
                        cpu_in_d      = stim_mem[stim_rd_nxt[SAW-1:0]];
                    end
                end
                halt_hit    = (stab_d == HALT_LIM);
                timeout_hit = ({16'd0, cycle_count_d} == TIMEOUT_W);
                if (halt_hit || timeout_hit) begin
                    state_d        = S_DONE;
                    cpu_rst_d      = 1'b1;
                    stim_restart_d = 1'b1;
                    halted_d       = halt_hit;
                    timed_out_d    = timeout_hit;
                end
            end

            default: begin
                state_d   = S_IDLE;
                cpu_rst_d = 1'b1;
            end
        endcase
    end

    // Control and status registers, asynchronously reset to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            stim_cnt_q     <= '0;
            stim_restart_q <= 1'b0;
            stim_rd_ptr_q  <= '0;
            cpu_in_q       <= '0;
            cap_wr_ptr_q   <= '0;
            cap_rd_ptr_q   <= '0;
            cap_count_q    <= '0;
            cap_rd_data_q  <= '0;
            prev_out_q     <= '0;
            prev_pc_q      <= '0;
            stab_q         <= '0;
            cycle_count_q  <= '0;
            halted_q       <= 1'b0;
            timed_out_q    <= 1'b0;
            cap_ovf_q      <= 1'b0;
            cpu_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            stim_cnt_q     <= stim_cnt_d;
            stim_restart_q <= stim_restart_d;
            stim_rd_ptr_q  <= stim_rd_ptr_d;
            cpu_in_q       <= cpu_in_d;
            cap_wr_ptr_q   <= cap_wr_ptr_d;
            cap_rd_ptr_q   <= cap_rd_ptr_d;
            cap_count_q    <= cap_count_d;
            cap_rd_data_q  <= cap_rd_data_d;
            prev_out_q     <= prev_out_d;
            prev_pc_q      <= prev_pc_d;
            stab_q         <= stab_d;
            cycle_count_q  <= cycle_count_d;
            halted_q       <= halted_d;
            timed_out_q    <= timed_out_d;
            cap_ovf_q      <= cap_ovf_d;
            cpu_rst_q      <= cpu_rst_d;
        end
    end

    // Stimulus buffer write port
    always_ff @(posedge clk) begin
        if (stim_we) begin
            stim_mem[stim_wr_idx] <= stim_wr_data;
        end
    end

    // Capture buffer write port
    always_ff @(posedge clk) begin
        if (cap_we) begin
            cap_mem[cap_wr_ptr_q] <= cpu_out;
        end
    end

    assign cap_rd_data = cap_rd_data_q;
    assign cap_count   = cap_count_q;
    assign cpu_rst     = cpu_rst_q;
    assign cpu_in      = cpu_in_q;
    assign running     = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign cap_ovf     = cap_ovf_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_port_harness.md
Name: cpu_port_harness

Overview:
- Synthesizable, parametrised run controller for the yfcpu core, for FPGA self-test and simulation.
- Holds the CPU in reset until started, then feeds the CPU input port from a preloaded stimulus buffer.
- Captures every change on the CPU output port into a readback buffer.
- Ends the run on a PC halt loop or a cycle timeout, and reports status.

Parameters:
- DATA_W, 16, width of CPU I/O ports.
- PC_W, 16, width of CPU program counter.
- STIM_DEPTH, 16, stimulus entries; power of two.
- CAP_DEPTH, 16, capture entries; power of two.
- TIMEOUT, 650, maximum run cycles.
- HALT_CYC, 4, consecutive cycles with unchanged PC that count as a halt; must be ≥2.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; starts a run from IDLE or DONE.
- stim_wr_en, in, 1, write stimulus entry; honoured in IDLE/DONE only.
- stim_wr_data, in, DATA_W, stimulus entry value.
- cap_rd_en, in, 1, pop capture entry; honoured in DONE only.
- cap_rd_data, out, DATA_W, capture head entry, registered.
- cap_count, out, log2(CAP_DEPTH)+1, number of valid capture entries.
- cpu_rst, out, 1, CPU reset (active-high, matches yfcpu).
- cpu_in, out, DATA_W, drives CPU p2.
- cpu_out, in, DATA_W, CPU p1.
- cpu_pc, in, PC_W, CPU pc.
- running, out, 1, high in RUN.
- done, out, 1, high in DONE.
- halted, out, 1, run ended by halt detection.
- timed_out, out, 1, run ended by timeout.
- cap_ovf, out, 1, a capture was dropped because the buffer was full.
- cycle_count, out, 16, RUN cycles elapsed; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; cpu_rst=1; cpu_in=0; all flags 0; cycle_count=0; cap_count=0; cap_rd_data=0.
  - Stimulus write pointer = 0 and read pointer = 0.
- State IDLE:
  - cpu_rst=1.
  - stim_wr_en writes the entry and increments the write pointer.
  - Writes beyond STIM_DEPTH entries are ignored.
- IDLE --start--> RUN:
  - On the transition edge, clear the capture buffer, flags and cycle_count, and reset the stimulus read pointer.
  - cpu_in loads stim[0], or 0 if the stimulus buffer is empty.
  - cpu_rst goes to 0 in the first RUN cycle.
  - Latch prev_out=cpu_out and prev_pc=cpu_pc.
- State RUN, each cycle:
  - cycle_count increments.
  - If cpu_out != prev_out:
    - Push cpu_out to the capture buffer; if full, drop it and set cap_ovf (sticky).
    - Advance the stimulus read pointer; cpu_in takes the next entry on the following cycle.
    - At the last written entry, hold cpu_in; no wrap.
  - prev_out and prev_pc update every cycle.
  - PC stability counter: increments when cpu_pc == prev_pc, else clears to 0.
- Termination:
  - Halt: stability counter reaches HALT_CYC-1 → halted=1.
  - Timeout: cycle_count reaches TIMEOUT → timed_out=1.
  - Either condition → DONE next edge. If both occur in the same cycle, set both flags.
- State DONE:
  - cpu_rst=1; flags and cycle_count hold.
  - cap_rd_en with cap_count>0: cap_rd_data = head entry next cycle; cap_count decrements.
  - cap_rd_en with cap_count=0: ignored, data holds.
  - start → RUN, same clearing as from IDLE; the stimulus contents are retained.
  - stim_wr_en in DONE first resets the write pointer to 0 when it is the first write after the run.
- Ignored inputs:
  - start during RUN is ignored.
  - stim_wr_en during RUN is ignored.
  - cap_rd_en outside DONE is ignored.
- Mid-run reset: rst low during RUN immediately forces IDLE, asserts cpu_rst, and loses capture contents.
- Width rules:
  - Pointers are log2(depth) bits.
  - cap_count is log2(CAP_DEPTH)+1 bits and reaches CAP_DEPTH when full.
  - cycle_count is compared to TIMEOUT zero-extended.

Test Plan:
- Reset and idle: rst low then high, no start → cpu_rst=1, cpu_in=0, running=0, done=0 after 20 cycles.
- Output capture, halt end: load stim {16'h0003,16'h0005}; start; model CPU drives cpu_out 0→7→9 then holds pc → captures {7,9}; cpu_in 3 then 5 then held at 5; halted=1, timed_out=0, cap_count=2.
- Timeout: stim empty, cpu_pc incrementing each cycle, TIMEOUT=650 → done after 650 RUN cycles, timed_out=1, halted=0, cycle_count=650.
- Capture overflow: CAP_DEPTH=16; cpu_out toggles 20 times → cap_count=16, cap_ovf=1; readback returns the first 16 values in order, then cap_count=0 and a further cap_rd_en is ignored.
- Simultaneous end: pc frozen such that halt detection and TIMEOUT coincide on the same cycle → halted=1 and timed_out=1.
- Mid-run reset and restart: rst low at RUN cycle 10 → cpu_rst=1 asynchronously, state IDLE, cap_count=0; start again → normal run, cycle_count restarts at 0.
